// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 4-bit ALU operation sequencer.
package alu_seq_pkg;

  localparam int ENTRY_W = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_OP1,
    S_OP2,
    S_OPC,
    S_CAP,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] op2;
    logic [3:0] op1;
  } entry_t;

  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_AND  = 4'd2;
  localparam logic [3:0] OPC_OR   = 4'd3;
  localparam logic [3:0] OPC_NOT  = 4'd4;
  localparam logic [3:0] OPC_NAND = 4'd5;
  localparam logic [3:0] OPC_NOR  = 4'd6;

  localparam int FLAG_SIGN  = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DONE  = 0;

endpackage

// File: rtl/alu_seq_fifo.sv
// DEPTH x 12-bit synchronous FIFO with registered full/empty flags.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  // Pointer/occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    full_d   = (count_d == (PTR_W+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues whole ALU operations and feeds them nibble-by-nibble into the
// sequential ALU, capturing each result onto a valid/ready output port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op1,
  input  logic [3:0]       in_op2,
  input  logic [3:0]       in_opcode,
  output logic             alu_reset,
  output logic [3:0]       alu_data,
  input  logic [3:0]       alu_result,
  input  logic [3:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic [2:0]       out_flags,
  output logic             out_err,
  output logic [CNT_W-1:0] ops_done
);

  state_e             state_q, state_d;
  entry_t             entry_q, entry_d;
  logic               out_valid_q, out_valid_d;
  logic [3:0]         out_result_q, out_result_d;
  logic [2:0]         out_flags_q, out_flags_d;
  logic               out_err_q, out_err_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rd_data;
  entry_t             in_entry;

  assign in_entry   = '{opcode: in_opcode, op2: in_op2, op1: in_op1};
  assign in_ready   = !fifo_full;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;
  assign ops_done   = ops_done_q;

  alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid && in_ready),
    .wr_data (in_entry),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, ALU drive and capture logic. ALU outputs decode from state
  // only, so an async reset to IDLE raises alu_reset without a clock edge.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    ops_done_d   = ops_done_q;
    fifo_pop     = 1'b0;
    alu_reset    = 1'b0;
    alu_data     = 4'd0;
    case (state_q)
      S_IDLE: begin
        alu_reset = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          entry_d  = entry_t'(fifo_rd_data);
          state_d  = S_RST;
        end
      end
      S_RST: begin
        alu_reset = 1'b1;
        state_d   = S_OP1;
      end
      S_OP1: begin
        alu_data = entry_q.op1;
        state_d  = S_OP2;
      end
      S_OP2: begin
        alu_data = entry_q.op2;
        state_d  = S_OPC;
      end
      S_OPC: begin
        alu_data = entry_q.opcode;
        state_d  = S_CAP;
      end
      S_CAP: begin
        out_result_d = alu_result;
        out_flags_d  = alu_flags[FLAG_SIGN:FLAG_CARRY];
        out_err_d    = !alu_flags[FLAG_DONE];
        out_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (ops_done_q != {CNT_W{1'b1}}) ops_done_d = ops_done_q + CNT_W'(1);
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            entry_d  = entry_t'(fifo_rd_data);
            state_d  = S_RST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= 4'd0;
      out_flags_q  <= 3'd0;
      out_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // In-flight operation; only read in OP1..OPC, after it has been loaded.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural 4-bit ALU.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op1 = 4'd0, in_op2 = 4'd0, in_opcode = 4'd0;
  logic       alu_reset;
  logic [3:0] alu_data;
  logic [3:0] alu_result = 4'd0, alu_flags = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic [2:0] out_flags;
  logic       out_err;
  logic [1:0] ops_done;

  alu_op_sequencer #(.DEPTH(4), .CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_opcode  (in_opcode),
    .alu_reset  (alu_reset),
    .alu_data   (alu_data),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    logic [2:0] flg;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_v = 1'b0;
  exp_t mon_e;

  logic [3:0] m_a = 4'd0, m_b = 4'd0;
  int         m_cnt = 0;

  logic [3:0] so_rst  [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] so_data [5] = '{4'd0, 4'd3, 4'd4, 4'd0, 4'd0};
  logic [7:0] sat_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

  // Reference ALU: {result, sign, zero, carry, done}; opcode F models a hung op.
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] opc);
    logic [4:0] w;
    logic [3:0] r;
    logic       c;
    c = 1'b0;
    r = 4'd0;
    w = 5'd0;
    case (opc)
      OPC_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; end
      OPC_SUB:  begin w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = w[4]; end
      OPC_AND:  r = a & b;
      OPC_OR:   r = a | b;
      OPC_NOT:  r = ~a;
      OPC_NAND: r = ~(a & b);
      OPC_NOR:  r = ~(a | b);
      4'hF:     return {4'h0, 4'b1100};
      default:  r = 4'd0;
    endcase
    return {r, r[3], (r == 4'd0), c, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: collects three nibbles after reset, then drives result.
  always @(posedge clk) begin
    if (alu_reset) begin
      m_cnt      <= 0;
      alu_result <= 4'd0;
      alu_flags  <= 4'd0;
    end else begin
      case (m_cnt)
        0: begin m_a <= alu_data; m_cnt <= 1; end
        1: begin m_b <= alu_data; m_cnt <= 2; end
        2: begin {alu_result, alu_flags} <= alu_ref(m_a, m_b, alu_data); m_cnt <= 3; end
        default: ;
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records out_valid rises, scores each handshake in order.
  always @(negedge clk) begin
    prev_v <= out_valid;
    if (reset && out_valid && !prev_v) rise_q.push_back(cyc);
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 8'(out_valid), 8'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_result", 8'(out_result), 8'(mon_e.res));
        check("out_flags", 8'(out_flags), 8'(mon_e.flg));
        check("out_err", 8'(out_err), 8'(mon_e.err));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rise_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         output bit acc);
    logic [7:0] rf;
    exp_t e;
    in_op1 = a;
    in_op2 = b;
    in_opcode = c;
    in_valid = 1'b1;
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) begin
      rf = alu_ref(a, b, c);
      e.res = rf[7:4];
      e.flg = rf[3:1];
      e.err = !rf[0];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n_acc;
    int n;

    // Reset state
    do_reset();
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_result", 8'(out_result), 8'd0);
    check("rst_out_flags", 8'(out_flags), 8'd0);
    check("rst_out_err", 8'(out_err), 8'd0);
    check("rst_ops_done", 8'(ops_done), 8'd0);
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_alu_reset", 8'(alu_reset), 8'd1);
    check("rst_alu_data", 8'(alu_data), 8'd0);

    // Single op with per-cycle ALU drive sequence
    push_op(4'd3, 4'd4, OPC_ADD, acc);
    check("single_accept", 8'(acc), 8'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("single_alu_reset_t%0d", k + 1), 8'(alu_reset), 8'(so_rst[k]));
      check($sformatf("single_alu_data_t%0d", k + 1), 8'(alu_data), 8'(so_data[k]));
      check($sformatf("single_no_valid_t%0d", k + 1), 8'(out_valid), 8'd0);
    end
    @(posedge clk);
    #1;
    check("single_out_valid_t6", 8'(out_valid), 8'd1);
    check("single_out_result", 8'(out_result), 8'd7);
    check("single_out_flags", 8'(out_flags), 8'd0);
    check("single_out_err", 8'(out_err), 8'd0);
    out_ready = 1'b1;
    wait_drain();
    check("single_ops_done", 8'(ops_done), 8'd1);

    // Back-to-back, spacing of out_valid pulses
    do_reset();
    out_ready = 1'b1;
    push_op(4'd3, 4'd5, OPC_SUB, acc);
    push_op(4'hC, 4'hA, OPC_AND, acc);
    push_op(4'd9, 4'd9, OPC_SUB, acc);
    wait_drain();
    check("b2b_ops_done", 8'(ops_done), 8'd3);
    check("b2b_rises", 8'(rise_q.size()), 8'd3);
    if (rise_q.size() == 3) begin
      check("b2b_gap1", 8'(rise_q[1] - rise_q[0]), 8'd6);
      check("b2b_gap2", 8'(rise_q[2] - rise_q[1]), 8'd6);
    end

    // Backpressure until full, then drain
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      push_op(4'(i + 1), 4'd1, OPC_ADD, acc);
      if (acc) n_acc++;
    end
    check("full_accepted", 8'(n_acc), 8'd5);
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready_low", 8'(in_ready), 8'd0);
    check("full_out_valid", 8'(out_valid), 8'd1);
    out_ready = 1'b1;
    check("full_in_ready_before_pop", 8'(in_ready), 8'd0);
    @(posedge clk);
    #1;
    check("full_in_ready_after_pop", 8'(in_ready), 8'd1);
    wait_drain();
    check("full_ops_done_sat", 8'(ops_done), 8'd3);

    // Missing done flag, then a clean op clears out_err
    do_reset();
    out_ready = 1'b1;
    push_op(4'd5, 4'd6, 4'hF, acc);
    push_op(4'd1, 4'd1, OPC_ADD, acc);
    wait_drain();
    check("nodone_ops_done", 8'(ops_done), 8'd2);
    check("nodone_err_cleared", 8'(out_err), 8'd0);

    // Async reset during OP2 with two ops queued
    do_reset();
    out_ready = 1'b1;
    push_op(4'd9, 4'hA, OPC_SUB, acc);
    push_op(4'd1, 4'd2, OPC_ADD, acc);
    push_op(4'd3, 4'd4, OPC_OR, acc);
    n = 0;
    while (!(alu_reset == 1'b0 && alu_data == 4'hA) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("arst_reached_op2", 8'(alu_data), 8'hA);
    #2;
    reset = 1'b0;
    #1;
    check("arst_alu_reset_async", 8'(alu_reset), 8'd1);
    check("arst_alu_data_async", 8'(alu_data), 8'd0);
    check("arst_out_valid_async", 8'(out_valid), 8'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("arst_idle_alu_reset", 8'(alu_reset), 8'd1);
    check("arst_out_valid", 8'(out_valid), 8'd0);
    check("arst_in_ready", 8'(in_ready), 8'd1);
    check("arst_ops_done", 8'(ops_done), 8'd0);

    // Counter saturation at 2 bits
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_op(4'(i + 2), 4'd3, OPC_OR, acc);
      wait_drain();
      check($sformatf("sat_ops_done_%0d", i + 1), 8'(ops_done), sat_exp[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
